// File: rtl/ctrl_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, FSM states,
// instruction field positions and the decoded-instruction bundle.
package ctrl_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned OP_HI = 8;
  localparam int unsigned OP_LO = 5;
  localparam int unsigned RA_HI = 4;
  localparam int unsigned RA_LO = 2;
  localparam int unsigned RB_HI = 1;
  localparam int unsigned RB_LO = 0;
  localparam int unsigned MEM_CNT_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_LD   = 4'b0010;
  localparam logic [OP_W-1:0] OP_ST   = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0110;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SHL  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_RST  = 4'b1010;
  localparam logic [OP_W-1:0] OP_HALT = 4'b1011;
  localparam logic [OP_W-1:0] OP_BR   = 4'b1100;
  localparam logic [OP_W-1:0] OP_LT   = 4'b1101;
  localparam logic [OP_W-1:0] OP_EQL  = 4'b1110;
  localparam logic [OP_W-1:0] OP_ILL  = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  typedef struct packed {
    logic is_wb;
    logic is_mem;
    logic is_load;
    logic is_cmp;
    logic is_br;
    logic is_halt;
    logic is_ill;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier.
// Ports: op (opcode field of IR) -> dec (instruction class flags).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output dec_t            dec
);

  always_comb begin
    dec = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: dec.is_wb = 1'b1;
      OP_LD: begin
        dec.is_mem  = 1'b1;
        dec.is_load = 1'b1;
      end
      OP_ST:          dec.is_mem  = 1'b1;
      OP_LT, OP_EQL:  dec.is_cmp  = 1'b1;
      OP_BR:          dec.is_br   = 1'b1;
      OP_HALT:        dec.is_halt = 1'b1;
      OP_ILL:         dec.is_ill  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/control sequencer for the 8-bit ALU.
// Fetches instruction words over InstValid/InstReady, decodes them into
// AluOp and register selects, sequences writeback, load/store enables,
// conditional branches and halt, and owns the carry and compare flags.
// Ports: Clk, Reset (sync, active-high), Start, InstValid/Inst/InstReady,
//   AluOp/AluCarryIn to ALU, AluOut/AluOverflow/AluZero from ALU,
//   RegRdA/RegRdB/RegWrEn/RegWrSel, MemRdEn/MemWrEn, BranchTaken/BranchTarget,
//   Done, IllegalOp. With PERF_CNT_EN defined: CycleCnt, RetireCnt.
// Control outputs are registered from the next-state values, so they line
// up with the state they belong to; BranchTarget forwards AluOut while
// BranchTaken is high.
module alu_issue_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned INST_W   = 9,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MEM_WAIT = 1
`ifdef PERF_CNT_EN
  ,
  parameter int unsigned CNT_W    = 16
`endif
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              InstValid,
  input  logic [INST_W-1:0] Inst,
  output logic              InstReady,
  output logic [3:0]        AluOp,
  output logic              AluCarryIn,
  input  logic [DATA_W-1:0] AluOut,
  input  logic              AluOverflow,
  input  logic              AluZero,
  output logic [2:0]        RegRdA,
  output logic [1:0]        RegRdB,
  output logic              RegWrEn,
  output logic              RegWrSel,
  output logic              MemRdEn,
  output logic              MemWrEn,
  output logic              BranchTaken,
  output logic [DATA_W-1:0] BranchTarget,
  output logic              Done,
  output logic              IllegalOp
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  CycleCnt,
  output logic [CNT_W-1:0]  RetireCnt
`endif
);

  state_t                state, state_d;
  logic [INST_W-1:0]     ir, ir_d;
  logic [MEM_CNT_W-1:0]  mem_cnt, mem_cnt_d;
  logic                  cond, cond_d;
  logic                  carry_d, ill_d;
  logic                  accept;
  dec_t                  dec;

  logic                  inst_ready_d, reg_wr_en_d, reg_wr_sel_d;
  logic                  mem_rd_en_d, mem_wr_en_d, branch_d, done_d;
  logic [3:0]            alu_op_d;
  logic [2:0]            reg_rd_a_d;
  logic [1:0]            reg_rd_b_d;
  logic                  in_op, mem_last;

  // Zero flag is not needed by any sequencing decision.
  logic                  unused_zero;
  assign unused_zero = AluZero;

  assign accept = (state == S_FETCH) && InstValid && InstReady;

  // ir_d equals ir outside FETCH, so one decoder serves both the EXEC
  // actions and the registered outputs of the upcoming state.
  ctrl_decode u_decode (
    .op  (ir_d[OP_HI:OP_LO]),
    .dec (dec)
  );

  // Next state, IR, flags and next-cycle output values.
  always_comb begin
    state_d   = state;
    ir_d      = ir;
    mem_cnt_d = mem_cnt;
    cond_d    = cond;
    carry_d   = AluCarryIn;
    ill_d     = IllegalOp;

    case (state)
      S_IDLE: if (Start) state_d = S_FETCH;
      S_FETCH: begin
        if (accept) begin
          ir_d    = Inst;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ir[OP_HI:OP_LO] == OP_ADD) carry_d = AluOverflow;
        if (ir[OP_HI:OP_LO] == OP_RST) carry_d = 1'b0;
        if (dec.is_cmp) cond_d = AluOut[0];
        if (dec.is_br && cond) cond_d = 1'b0;
        if (dec.is_ill) ill_d = 1'b1;
        if (dec.is_mem) begin
          state_d   = S_MEM;
          mem_cnt_d = MEM_CNT_W'(MEM_WAIT - 1);
        end else if (dec.is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_cnt == '0) state_d = S_FETCH;
        else mem_cnt_d = mem_cnt - MEM_CNT_W'(1);
      end
      S_HALT: if (Start) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    in_op        = (state_d == S_EXEC) || (state_d == S_MEM);
    mem_last     = (state_d == S_MEM) && (mem_cnt_d == '0);
    inst_ready_d = (state_d == S_FETCH);
    done_d       = (state_d == S_HALT);
    alu_op_d     = in_op ? ir_d[OP_HI:OP_LO] : 4'd0;
    reg_rd_a_d   = in_op ? ir_d[RA_HI:RA_LO] : 3'd0;
    reg_rd_b_d   = in_op ? ir_d[RB_HI:RB_LO] : 2'd0;
    reg_wr_en_d  = ((state_d == S_EXEC) && dec.is_wb) || (mem_last && dec.is_load);
    reg_wr_sel_d = mem_last && dec.is_load;
    mem_rd_en_d  = (state_d == S_MEM) && dec.is_load;
    mem_wr_en_d  = (state_d == S_MEM) && dec.is_mem && !dec.is_load;
    // cond only changes in EXEC, so entering EXEC sees its settled value.
    branch_d     = (state_d == S_EXEC) && dec.is_br && cond;
  end

  // State, flags and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      ir          <= '0;
      mem_cnt     <= '0;
      cond        <= 1'b0;
      AluCarryIn  <= 1'b0;
      IllegalOp   <= 1'b0;
      InstReady   <= 1'b0;
      AluOp       <= 4'd0;
      RegRdA      <= 3'd0;
      RegRdB      <= 2'd0;
      RegWrEn     <= 1'b0;
      RegWrSel    <= 1'b0;
      MemRdEn     <= 1'b0;
      MemWrEn     <= 1'b0;
      BranchTaken <= 1'b0;
      Done        <= 1'b0;
    end else begin
      state       <= state_d;
      ir          <= ir_d;
      mem_cnt     <= mem_cnt_d;
      cond        <= cond_d;
      AluCarryIn  <= carry_d;
      IllegalOp   <= ill_d;
      InstReady   <= inst_ready_d;
      AluOp       <= alu_op_d;
      RegRdA      <= reg_rd_a_d;
      RegRdB      <= reg_rd_b_d;
      RegWrEn     <= reg_wr_en_d;
      RegWrSel    <= reg_wr_sel_d;
      MemRdEn     <= mem_rd_en_d;
      MemWrEn     <= mem_wr_en_d;
      BranchTaken <= branch_d;
      Done        <= done_d;
    end
  end

  // Branch LUT index comes straight from the ALU during the branch EXEC cycle.
  assign BranchTarget = BranchTaken ? AluOut : '0;

`ifdef PERF_CNT_EN
  // Saturating activity and retirement counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      CycleCnt  <= '0;
      RetireCnt <= '0;
    end else begin
      if ((state != S_IDLE) && (state != S_HALT) && (CycleCnt != '1))
        CycleCnt <= CycleCnt + CNT_W'(1);
      if (accept && (RetireCnt != '1))
        RetireCnt <= RetireCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int unsigned MEM_W = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       InstValid = 1'b0;
  logic [8:0] Inst = '0;
  logic       InstReady;
  logic [3:0] AluOp;
  logic       AluCarryIn;
  logic [7:0] AluOut = '0;
  logic       AluOverflow = 1'b0;
  logic       AluZero = 1'b0;
  logic [2:0] RegRdA;
  logic [1:0] RegRdB;
  logic       RegWrEn, RegWrSel, MemRdEn, MemWrEn, BranchTaken, Done, IllegalOp;
  logic [7:0] BranchTarget;
`ifdef PERF_CNT_EN
  logic [15:0] CycleCnt, RetireCnt;
`endif

  int checks = 0;
  int errors = 0;

  // Architectural model state.
  bit m_carry, m_cond, m_ill;

  alu_issue_ctrl #(.INST_W(9), .DATA_W(8), .MEM_WAIT(MEM_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InstValid(InstValid), .Inst(Inst),
    .InstReady(InstReady), .AluOp(AluOp), .AluCarryIn(AluCarryIn), .AluOut(AluOut),
    .AluOverflow(AluOverflow), .AluZero(AluZero), .RegRdA(RegRdA), .RegRdB(RegRdB),
    .RegWrEn(RegWrEn), .RegWrSel(RegWrSel), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Done(Done),
    .IllegalOp(IllegalOp)
`ifdef PERF_CNT_EN
    , .CycleCnt(CycleCnt), .RetireCnt(RetireCnt)
`endif
  );

  always #5 Clk = ~Clk;

  wire [25:0] obs = {InstReady, AluOp, RegRdA, RegRdB, RegWrEn, RegWrSel, MemRdEn,
                     MemWrEn, BranchTaken, BranchTarget, Done, AluCarryIn, IllegalOp};

  function automatic logic [25:0] vec(input bit rdy, input logic [3:0] op, input logic [2:0] ra,
                                      input logic [1:0] rb, input bit wb, input bit sel,
                                      input bit rd, input bit wr, input bit bt,
                                      input logic [7:0] tgt, input bit done);
    return {rdy, op, ra, rb, wb, sel, rd, wr, bt, tgt, done, m_carry, m_ill};
  endfunction

  // Issue one instruction from FETCH and follow it to the next FETCH.
  task automatic run_inst(input logic [8:0] inst, input logic [7:0] aout, input bit ovf);
    logic [3:0]  op = inst[8:5];
    bit          wb, ld, st, halt, bt;
    logic [25:0] exp;
    int          n = 0;
    wb   = (op <= 4'd1) || (op >= 4'd4 && op <= 4'd9);
    ld   = (op == 4'd2);
    st   = (op == 4'd3);
    halt = (op == 4'd11);
    bt   = (op == 4'd12) && m_cond;
    while (!InstReady && n < 20) begin @(negedge Clk); n++; end
    checks++;
    if (!InstReady) begin
      errors++;
      $display("FAIL ready_timeout: InstReady=%b want 1", InstReady);
      return;
    end
    Inst = inst; InstValid = 1'b1; AluOut = aout; AluOverflow = ovf; AluZero = (aout == 8'd0);
    @(negedge Clk);
    InstValid = 1'b0;
    exp = vec(0, op, inst[4:2], inst[1:0], wb, 0, 0, 0, bt, bt ? aout : 8'd0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL exec op=%h: got %h want %h", op, obs, exp);
    end
    if (op == 4'd0) m_carry = ovf;
    if (op == 4'd10) m_carry = 1'b0;
    if (op == 4'd13 || op == 4'd14) m_cond = aout[0];
    if (bt) m_cond = 1'b0;
    if (op == 4'd15) m_ill = 1'b1;
    if (ld || st) begin
      for (int k = 1; k <= int'(MEM_W); k++) begin
        @(negedge Clk);
        exp = vec(0, op, inst[4:2], inst[1:0], ld && k == int'(MEM_W), ld && k == int'(MEM_W),
                  ld, st, 0, 8'd0, 0);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL mem op=%h cyc=%0d: got %h want %h", op, k, obs, exp);
        end
      end
    end
    if (halt) begin
      InstValid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge Clk);
        exp = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 1);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL halt cyc=%0d: got %h want %h", k, obs, exp);
        end
      end
      Start = 1'b1;
    end
    @(negedge Clk);
    Start = 1'b0; InstValid = 1'b0;
    exp = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL next_fetch op=%h: got %h want %h", op, obs, exp);
    end
  endtask

  task automatic test_reset;
    logic [25:0] exp;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    m_carry = 0; m_cond = 0; m_ill = 0;
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset: got %h want %h", obs, exp); end
    Reset = 1'b0; InstValid = 1'b1;
    @(negedge Clk);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL idle_hold: got %h want %h", obs, exp); end
    InstValid = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    exp = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL start: got %h want %h", obs, exp); end
  endtask

  task automatic test_add_carry;
    run_inst({4'b0000, 3'd1, 2'd2}, 8'h10, 1'b1);
    checks++;
    if (AluCarryIn !== 1'b1) begin errors++; $display("FAIL add_carry: got %b want 1", AluCarryIn); end
  endtask

  task automatic test_rst;
    run_inst({4'b1010, 3'd0, 2'd0}, 8'h00, 1'b1);
    checks++;
    if (AluCarryIn !== 1'b0) begin errors++; $display("FAIL rst_carry: got %b want 0", AluCarryIn); end
  endtask

  task automatic test_branch;
    run_inst({4'b1110, 3'd2, 2'd3}, 8'h01, 1'b0);
    run_inst({4'b1100, 3'd4, 2'd1}, 8'h05, 1'b0);
    run_inst({4'b1100, 3'd4, 2'd1}, 8'h07, 1'b0);
    run_inst({4'b1101, 3'd1, 2'd0}, 8'h00, 1'b0);
    run_inst({4'b1100, 3'd0, 2'd0}, 8'h09, 1'b0);
  endtask

  task automatic test_mem;
    run_inst({4'b0010, 3'd5, 2'd1}, 8'h20, 1'b0);
    run_inst({4'b0011, 3'd6, 2'd2}, 8'h21, 1'b0);
  endtask

  task automatic test_halt_illegal;
    run_inst({4'b0000, 3'd3, 2'd3}, 8'hff, 1'b1);
    run_inst({4'b1011, 3'd0, 2'd0}, 8'h00, 1'b0);
    checks++;
    if (AluCarryIn !== 1'b1) begin errors++; $display("FAIL halt_keep_carry: got %b want 1", AluCarryIn); end
    run_inst({4'b1111, 3'd7, 2'd3}, 8'h00, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 150; i++)
      run_inst(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid_store;
    logic [25:0] exp;
    run_inst({4'b0000, 3'd1, 2'd1}, 8'h01, 1'b1);
    run_inst({4'b1111, 3'd0, 2'd0}, 8'h00, 1'b0);
    Inst = {4'b0011, 3'd2, 2'd1}; InstValid = 1'b1;
    @(negedge Clk);
    InstValid = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (MemWrEn !== 1'b1) begin errors++; $display("FAIL store_mem2: got %b want 1", MemWrEn); end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    m_carry = 0; m_cond = 0; m_ill = 0;
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_abort: got %h want %h", obs, exp); end
    @(negedge Clk);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, exp); end
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    run_inst({4'b1100, 3'd0, 2'd0}, 8'h33, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_rst();
    test_branch();
    test_mem();
    test_halt_illegal();
    test_random();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
